// File: rtl/sqrt_seq_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_seq_pkg
// Shared definitions for the sequencer that drives a squareroot_f32 unit.
//   state_e     : FSM state encoding (IDLE / LOAD / RUN / DONE)
//   QNAN_F32    : canonical quiet NaN returned when the unit never answers
//   CNT_W       : width of the shared LOAD/RUN cycle counter
// ---------------------------------------------------------------------------
package sqrt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] QNAN_F32 = 32'h7fc0_0000;

  localparam int CNT_W = 8;

endpackage : sqrt_seq_pkg

// File: rtl/sqrt_f32_seq.sv
// ---------------------------------------------------------------------------
// sqrt_f32_seq
// Sequencer wrapped around an externally instantiated squareroot_f32 unit.
// An operand is accepted on a valid/ready handshake, the unit is held in its
// load state (sq_rst=1) for HOLD_CYCLES cycles, then released to compute.
// The first rdy seen after release is ignored because it may be left over
// from the previous operation. If no qualified rdy arrives within TIMEOUT
// RUN cycles the operation is aborted and a quiet NaN is returned with
// out_timeout set. Results are held until the downstream consumer accepts.
//
// Parameters
//   HOLD_CYCLES : cycles sq_rst is held high per operand (1..15)
//   TIMEOUT     : maximum RUN cycles waiting for sq_rdy (4..255)
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake, in_a is the f32 operand
//   sq_rst, sq_a          : load/start and operand towards squareroot_f32
//   sq_rdy, sq_sqrt       : ready flag and result from squareroot_f32
//   out_valid/out_ready   : result handshake
//   out_sqrt, out_timeout : registered result and abort qualifier
//   busy                  : high while loading or computing
// ---------------------------------------------------------------------------
module sqrt_f32_seq
  import sqrt_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int TIMEOUT     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        sq_rst,
  output logic [31:0] sq_a,
  input  logic        sq_rdy,
  input  logic [31:0] sq_sqrt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sqrt,
  output logic        out_timeout,
  output logic        busy
);

  // Terminal counts, sized to the counter so the compares are width-exact.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sq_a_q;
  logic [31:0]      out_sqrt_q;
  logic             out_timeout_q;
  logic             out_valid_q;

  // A qualified rdy: the unit says done and this is not the first RUN cycle,
  // where a rdy may still be asserted from the operation before.
  logic rdy_qualified;
  assign rdy_qualified = sq_rdy && (cnt_q != '0);

  // -------------------------------------------------------------------------
  // FSM, counter and datapath registers.
  // NOTE: every register here is assigned with <= so all of them update
  // together from the values present before the edge; blocking assignments
  // would let a later statement see an already-updated state or counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sq_a_q        <= '0;
      out_sqrt_q    <= '0;
      out_timeout_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sq_a_q  <= in_a;
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // A genuine result takes priority over the timeout in the same
          // cycle, so the rdy check is evaluated first.
          if (rdy_qualified) begin
            out_sqrt_q    <= sq_sqrt;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= ST_DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            out_sqrt_q    <= QNAN_F32;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              // Back-to-back: the next operand is taken in the same cycle
              // the result is consumed, skipping IDLE.
              sq_a_q  <= in_a;
              cnt_q   <= '0;
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from the state register. in_ready in DONE follows
  // out_ready so a new operand can be accepted while the result drains.
  // -------------------------------------------------------------------------
  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign sq_rst      = (state_q != ST_RUN);
  assign sq_a        = sq_a_q;
  assign out_valid   = out_valid_q;
  assign out_sqrt    = out_sqrt_q;
  assign out_timeout = out_timeout_q;

endmodule : sqrt_f32_seq
